register_file: RTL and testbench
================================

# register_file

Windowed SPARC V8 integer register file for the ICOM4215 datapath: 8 shared globals plus 4 overlapping windows of 24 visible registers each, giving 72 physical 32-bit registers. It is addressed by the current window pointer and a 5-bit architectural register number. It provides one combinational read port and one clocked write port. It sits between the instruction decode/control unit and the ALU operand path.

## Interface
- No parameters. Sizes are fixed: 32-bit data, 4 windows, 5-bit register number.
- Clk  input  1  single clock; all writes occur on its rising edge.
- Clr  input  1  reset, asynchronous, active-low; clears every physical register to 0.
- out  output  32  data of the addressed register (signed, pass-through).
- in  input  32  write data (signed, pass-through).
- enable  input  1  active-high block enable; gates writes.
- rw  input  1  1 = read, 0 = write.
- current_window  input  2  current window pointer (CWP), 0..3.
- r_num  input  5  architectural register number r0..r31.

## Operation
- Physical storage: G[0..7], plus W[w][0..15] for w = 0..3. Total 72 x 32 bits.
- Address map for window w = current_window, r = r_num:
  - r0..r7 (globals) map to G[r] and are shared by all windows.
  - r8..r15 (outs) map to W[w][r-8].
  - r16..r23 (locals) map to W[w][r-8].
  - r24..r31 (ins) map to W[(w+1) mod 4][r-24].
- Window overlap: the ins of window w are the same physical registers as the outs of window w+1.
- Wrap-around: the ins of window 3 are the outs of window 0.
- r0 always reads 0. A write to r0 is ignored.
- Read: out = contents of the mapped register. The path is purely combinational and does not depend on enable, rw or Clk.
- Write: on a rising Clk edge with enable=1, rw=0 and Clr=1, `in` is stored into the mapped register. Exactly one physical register changes.
- rw=1 or enable=0: no register changes.
- Data is stored bit-exact. There is no arithmetic and no sign handling.

## Timing
- Reset: while Clr=0, all 72 registers are 0, so out=0 for every address. Reset takes effect immediately, independent of Clk.
- Reset mid-operation: a Clr falling edge overrides any write pending in that cycle. The first write after release happens on the first rising Clk edge at which Clr=1.
- Write latency: the new value is visible on out, through the combinational read, immediately after the write edge if the address is unchanged.
- Read latency: 0 cycles. out follows changes on current_window or r_num within the same cycle.
- Read during write cycle: before the edge, out shows the old value; after the edge, it shows the new value. There is no internal bypass.
- Window change: takes effect combinationally. No register contents move; only the mapping changes.
- No handshake and no busy state. A write can be issued every cycle.

## Test plan
- Reset: Clr=0, then sweep all 4 windows x 32 registers -> out=0 everywhere. Pulse Clr low after writes -> all 0 again, with no clock edge needed.
- Per-window write/read sweep: for each window, write in=r to each r1..r31 (rw=0, enable=1), then read back with rw=1 -> out=r, except r0 -> 0.
- Globals sharing: window 0, write r5=0x1234 -> read r5 in windows 1, 2, 3 -> 0x1234.
- Window overlap and wrap-around:
  - Window 1, write r8=0xAAAA5555 -> window 0 r24 reads 0xAAAA5555.
  - Window 0, write r15=-1 -> window 3 r31 reads 0xFFFFFFFF.
  - Window 2 locals are not visible as window 1 or window 3 locals.
- Write gating:
  - rw=1 with in=77 on r10 -> value unchanged.
  - enable=0, rw=0, in=99 -> unchanged.
  - Write to r0 with in=5 -> r0 still reads 0.
- Back-to-back writes: write r20 on consecutive edges with 1, then 2, then 3 -> out shows each value one edge after the previous, final value 3. A different window's r20 stays unchanged.

Source files
------------

// File: rtl/register_file.sv
// Windowed SPARC V8 integer register file: 8 globals + 4 overlapping 16-register windows.
// One combinational read port and one clocked write port, addressed by CWP and r_num.
module register_file (
    input  logic        Clk,
    input  logic        Clr,
    output logic [31:0] out,
    input  logic [31:0] in,
    input  logic        enable,
    input  logic        rw,
    input  logic [1:0]  current_window,
    input  logic [4:0]  r_num
);

    localparam int unsigned NumRegs = 72;

    // Physical layout: [0..7] globals, then window w occupies [8+16w .. 8+16w+15].
    logic [31:0] regs_q [NumRegs];
    logic [6:0]  phys_idx;
    logic [1:0]  win_sel;
    logic [3:0]  win_off;
    logic        wr_en;

    always_comb begin
        // Ins (r24..r31) alias the outs of the next window, wrapping 3 -> 0.
        win_sel = (r_num[4:3] == 2'b11) ? current_window + 2'd1 : current_window;
        win_off = {(r_num[4:3] == 2'b10), r_num[2:0]};
        if (r_num[4:3] == 2'b00) begin
            phys_idx = {4'b0000, r_num[2:0]};
        end else begin
            phys_idx = 7'd8 + {1'b0, win_sel, win_off};
        end
    end

    assign wr_en = enable && !rw && (r_num != 5'd0);

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[phys_idx] <= in;
        end
    end

    assign out = (r_num == 5'd0) ? 32'd0 : regs_q[phys_idx];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, window mapping, overlap,
// write gating and back-to-back writes.
module tb_register_file;

    logic        Clk;
    logic        Clr;
    logic [31:0] out;
    logic [31:0] in;
    logic        enable;
    logic        rw;
    logic [1:0]  current_window;
    logic [4:0]  r_num;

    int total;
    int bad;

    register_file dut (
        .Clk            (Clk),
        .Clr            (Clr),
        .out            (out),
        .in             (in),
        .enable         (enable),
        .rw             (rw),
        .current_window (current_window),
        .r_num          (r_num)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] w, input logic [4:0] r, input logic [31:0] exp,
                      input string tag);
        current_window = w;
        r_num          = r;
        #1;
        check($sformatf("%s w%0d r%0d", tag, w, r), out, exp);
    endtask

    task automatic wr(input logic [1:0] w, input logic [4:0] r, input logic [31:0] d);
        current_window = w;
        r_num          = r;
        in             = d;
        rw             = 1'b0;
        enable         = 1'b1;
        @(posedge Clk);
        #1;
        enable = 1'b0;
        rw     = 1'b1;
    endtask

    task automatic sweep_zero(input string tag);
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                rd(w[1:0], r[4:0], 32'd0, tag);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        Clr            = 1'b0;
        in             = '0;
        enable         = 1'b0;
        rw             = 1'b1;
        current_window = '0;
        r_num          = '0;

        // Reset state everywhere
        #2;
        sweep_zero("reset");
        @(posedge Clk);
        #1;
        Clr = 1'b1;

        // Per-window write r -> read back r, r0 stays 0
        for (int w = 0; w < 4; w++) begin
            for (int r = 1; r < 32; r++) begin
                wr(w[1:0], r[4:0], 32'(r));
            end
            for (int r = 0; r < 32; r++) begin
                rd(w[1:0], r[4:0], 32'(r), "sweep");
            end
        end

        // Async reset pulse mid-cycle clears everything without a clock edge
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        rd(2'd1, 5'd17, 32'd0, "clr_pulse");
        sweep_zero("clr_pulse");
        Clr = 1'b1;

        // Globals shared across windows
        wr(2'd0, 5'd5, 32'h0000_1234);
        for (int w = 1; w < 4; w++) begin
            rd(w[1:0], 5'd5, 32'h0000_1234, "global");
        end

        // Overlap and wrap-around
        wr(2'd1, 5'd8, 32'hAAAA_5555);
        rd(2'd0, 5'd24, 32'hAAAA_5555, "overlap");
        wr(2'd0, 5'd15, 32'hFFFF_FFFF);
        rd(2'd3, 5'd31, 32'hFFFF_FFFF, "wrap");
        rd(2'd3, 5'd15, 32'd0, "wrap_outs");

        // Window 2 locals are private
        wr(2'd2, 5'd16, 32'hDEAD_BEEF);
        rd(2'd2, 5'd16, 32'hDEAD_BEEF, "local");
        rd(2'd1, 5'd16, 32'd0, "local_priv");
        rd(2'd3, 5'd16, 32'd0, "local_priv");

        // Write gating
        wr(2'd0, 5'd10, 32'h0000_0010);
        current_window = 2'd0;
        r_num          = 5'd10;
        in             = 32'd77;
        rw             = 1'b1;
        enable         = 1'b1;
        @(posedge Clk);
        #1;
        check("gate_rw", out, 32'h0000_0010);
        in     = 32'd99;
        rw     = 1'b0;
        enable = 1'b0;
        @(posedge Clk);
        #1;
        check("gate_en", out, 32'h0000_0010);
        rw = 1'b1;
        wr(2'd0, 5'd0, 32'd5);
        rd(2'd0, 5'd0, 32'd0, "r0_write");

        // Back-to-back writes on w1 r20; w3 r20 must stay put
        wr(2'd3, 5'd20, 32'h0000_0055);
        current_window = 2'd1;
        r_num          = 5'd20;
        in             = 32'd1;
        rw             = 1'b0;
        enable         = 1'b1;
        #1;
        check("b2b_pre", out, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge Clk);
            #1;
            check($sformatf("b2b_%0d", k), out, 32'(k));
            in = 32'(k + 1);
        end
        enable = 1'b0;
        rw     = 1'b1;
        rd(2'd3, 5'd20, 32'h0000_0055, "b2b_other");

        // Reset overrides a pending write; write lands on first edge after release
        current_window = 2'd0;
        r_num          = 5'd9;
        in             = 32'h0000_0077;
        rw             = 1'b0;
        enable         = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        @(posedge Clk);
        #1;
        check("clr_override", out, 32'd0);
        Clr = 1'b1;
        #1;
        check("clr_released", out, 32'd0);
        @(posedge Clk);
        #1;
        check("post_release", out, 32'h0000_0077);
        enable = 1'b0;
        rw     = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
